// File: rtl/fb_wr_coalescer.sv
// Framebuffer write coalescer: round-robin arbitration over NUM_CH pixel
// sources, packing address-contiguous runs from the granted source into
// AXI INCR bursts (one header, then a data stream) of up to MAX_BURST beats.
module fb_wr_coalescer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            s_valid,
    output logic [NUM_CH-1:0]            s_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic                         flush,
    output logic                         m_burst_valid,
    input  logic                         m_burst_ready,
    output logic [ADDR_WIDTH-1:0]        m_burst_addr,
    output logic [7:0]                   m_burst_len,
    output logic                         m_data_valid,
    input  logic                         m_data_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_data_last,
    output logic                         idle
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CW    = $clog2(MAX_BURST + 1);
    localparam int unsigned IW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned LW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StIssue, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         rd_q;
    logic [LW-1:0]         lock_q;
    logic [LW-1:0]         rr_ptr_q;
    logic [TW-1:0]         timer_q;
    logic                  burst_valid_q;
    logic [ADDR_WIDTH-1:0] burst_addr_q;
    logic [7:0]            burst_len_q;
    logic                  data_valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  data_last_q;
    logic [DATA_WIDTH-1:0] buf_q [MAX_BURST];

    logic [LW-1:0]         grant;
    logic                  grant_vld;
    logic [LW-1:0]         cand;
    logic [LW-1:0]         sel;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ADDR_WIDTH-1:0] expect_addr;
    logic [LW-1:0]         rr_next;
    logic                  can_append;
    logic                  take;
    logic                  close;

    assign expect_addr = base_q + ADDR_WIDTH'(count_q) * ADDR_WIDTH'(BYTES);
    assign rr_next     = (lock_q == LW'(NUM_CH - 1)) ? '0 : lock_q + LW'(1);
    assign idle        = (state_q == StIdle) && (s_valid == '0);

    assign m_burst_valid = burst_valid_q;
    assign m_burst_addr  = burst_addr_q;
    assign m_burst_len   = burst_len_q;
    assign m_data_valid  = data_valid_q;
    assign m_data        = data_q;
    assign m_data_last   = data_last_q;

    // Round-robin grant: first valid source at or above rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = LW'((32'(rr_ptr_q) + i) % NUM_CH);
            if (!grant_vld && s_valid[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    // Source of interest: the grant while idle, the locked source otherwise.
    always_comb begin
        sel       = (state_q == StIdle) ? grant : lock_q;
        sel_valid = s_valid[sel];
        sel_addr  = ADDR_WIDTH'(s_addr >> (32'(sel) * ADDR_WIDTH));
        sel_data  = DATA_WIDTH'(s_data >> (32'(sel) * DATA_WIDTH));
    end

    // FSM next state, source accept and burst close decision.
    always_comb begin
        state_d    = state_q;
        s_ready    = '0;
        take       = 1'b0;
        close      = 1'b0;
        can_append = sel_valid && (sel_addr == expect_addr) &&
                     (count_q < CW'(MAX_BURST)) && !flush && (sel_addr[11:0] != 12'h000);
        case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    s_ready = NUM_CH'(1) << grant;
                    take    = 1'b1;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (can_append) begin
                    s_ready = NUM_CH'(1) << lock_q;
                    take    = 1'b1;
                end else if (sel_valid || flush || (count_q == CW'(MAX_BURST)) ||
                             (timer_q == TW'(TIMEOUT))) begin
                    // A valid-but-rejected word stays pending for a later grant.
                    close   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (m_burst_ready) state_d = StDrain;
            end
            StDrain: begin
                if (m_data_ready && data_last_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Burst bookkeeping and registered header/data outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q        <= '0;
            count_q       <= '0;
            rd_q          <= '0;
            lock_q        <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            burst_valid_q <= 1'b0;
            burst_addr_q  <= '0;
            burst_len_q   <= '0;
            data_valid_q  <= 1'b0;
            data_q        <= '0;
            data_last_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (take) begin
                        base_q  <= sel_addr;
                        count_q <= CW'(1);
                        lock_q  <= grant;
                        timer_q <= '0;
                    end
                end
                StCollect: begin
                    if (take) begin
                        count_q <= count_q + CW'(1);
                        timer_q <= '0;
                    end else if (close) begin
                        burst_valid_q <= 1'b1;
                        burst_addr_q  <= base_q;
                        burst_len_q   <= 8'(count_q - CW'(1));
                    end else if (!sel_valid && (timer_q != TW'(TIMEOUT))) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StIssue: begin
                    if (m_burst_ready) begin
                        burst_valid_q <= 1'b0;
                        data_valid_q  <= 1'b1;
                        data_q        <= buf_q[0];
                        data_last_q   <= (count_q == CW'(1));
                        rd_q          <= CW'(1);
                    end
                end
                StDrain: begin
                    if (m_data_ready) begin
                        if (data_last_q) begin
                            data_valid_q <= 1'b0;
                            data_last_q  <= 1'b0;
                            count_q      <= '0;
                            rr_ptr_q     <= rr_next;
                        end else begin
                            data_q      <= buf_q[IW'(rd_q)];
                            data_last_q <= (rd_q == count_q - CW'(1));
                            rd_q        <= rd_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Word buffer; count is zero in idle so the first word lands in slot 0.
    always_ff @(posedge clk) begin
        if (take) buf_q[IW'(count_q)] <= sel_data;
    end

endmodule

// File: tb/tb_fb_wr_coalescer.sv
// Self-checking bench for fb_wr_coalescer: directed scenarios plus random
// multi-source traffic compared against a burst-level reference model.
module tb_fb_wr_coalescer;

    localparam int NUM_CH = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int MB     = 16;
    localparam int TO     = 8;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NUM_CH-1:0]      s_valid;
    logic [NUM_CH-1:0]      s_ready;
    logic [NUM_CH*AW-1:0]   s_addr;
    logic [NUM_CH*DW-1:0]   s_data;
    logic                   flush;
    logic                   m_burst_valid;
    logic                   m_burst_ready;
    logic [AW-1:0]          m_burst_addr;
    logic [7:0]             m_burst_len;
    logic                   m_data_valid;
    logic                   m_data_ready;
    logic [DW-1:0]          m_data;
    logic                   m_data_last;
    logic                   idle;

    fb_wr_coalescer #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_data(s_data), .flush(flush), .m_burst_valid(m_burst_valid),
        .m_burst_ready(m_burst_ready), .m_burst_addr(m_burst_addr), .m_burst_len(m_burst_len),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data(m_data),
        .m_data_last(m_data_last), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] src_addr [NUM_CH][$];
    logic [DW-1:0] src_data [NUM_CH][$];
    int            drv_pos  [NUM_CH];

    logic [AW-1:0] exp_addr[$], obs_addr[$];
    logic [7:0]    exp_len[$],  obs_len[$];
    logic [DW-1:0] exp_data[$], obs_data[$];
    logic          exp_last[$], obs_last[$];

    int  cyc = 0;
    int  acc_total, last_acc_cyc, hdr_rise_cyc, proto_err;
    int  model_rr = 0;
    bit  bp = 1'b0;
    bit  hold_data = 1'b0;

    logic          prev_bv, prev_br, prev_dv, prev_dr, prev_dl;
    logic [AW-1:0] prev_ba;
    logic [7:0]    prev_bl;
    logic [DW-1:0] prev_d;

    task automatic drive_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            if (drv_pos[c] < src_addr[c].size()) begin
                s_valid[c]           = 1'b1;
                s_addr[c*AW +: AW]   = src_addr[c][drv_pos[c]];
                s_data[c*DW +: DW]   = src_data[c][drv_pos[c]];
            end else begin
                s_valid[c]           = 1'b0;
                s_addr[c*AW +: AW]   = '0;
                s_data[c*DW +: DW]   = '0;
            end
        end
        m_burst_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_data_ready  = hold_data ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic clear_prev();
        prev_bv = 0; prev_br = 0; prev_dv = 0; prev_dr = 0; prev_dl = 0;
        prev_ba = '0; prev_bl = '0; prev_d = '0;
    endtask

    // One clock: sample handshakes mid-cycle, then drive the next cycle's inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s_valid[c] && s_ready[c]) begin
                drv_pos[c]++;
                acc_total++;
                last_acc_cyc = cyc;
            end
        end
        if (m_burst_valid && !prev_bv) hdr_rise_cyc = cyc;
        if (prev_bv && !prev_br &&
            !(m_burst_valid && m_burst_addr == prev_ba && m_burst_len == prev_bl)) proto_err++;
        if (prev_dv && !prev_dr &&
            !(m_data_valid && m_data == prev_d && m_data_last == prev_dl)) proto_err++;
        prev_bv = m_burst_valid; prev_br = m_burst_ready; prev_ba = m_burst_addr;
        prev_bl = m_burst_len;   prev_dv = m_data_valid;  prev_dr = m_data_ready;
        prev_d  = m_data;        prev_dl = m_data_last;
        if (m_burst_valid && m_burst_ready) begin
            obs_addr.push_back(m_burst_addr);
            obs_len.push_back(m_burst_len);
        end
        if (m_data_valid && m_data_ready) begin
            obs_data.push_back(m_data);
            obs_last.push_back(m_data_last);
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic clear_all();
        for (int c = 0; c < NUM_CH; c++) begin
            src_addr[c].delete();
            src_data[c].delete();
            drv_pos[c] = 0;
        end
        exp_addr.delete(); exp_len.delete(); exp_data.delete(); exp_last.delete();
        obs_addr.delete(); obs_len.delete(); obs_data.delete(); obs_last.delete();
        acc_total = 0; last_acc_cyc = -1; hdr_rise_cyc = -1; proto_err = 0;
    endtask

    task automatic push_run(int ch, logic [AW-1:0] start, int n, logic [DW-1:0] d0);
        for (int i = 0; i < n; i++) begin
            src_addr[ch].push_back(start + AW'(4 * i));
            src_data[ch].push_back(d0 + DW'(i));
        end
    endtask

    // Reference model: split each source's stream into bursts (contiguity,
    // MAX_BURST, 4 KiB boundary) and order bursts round-robin over sources
    // that still have pending words.
    task automatic build_expected();
        int pos [NUM_CH];
        int ch, n;
        logic [AW-1:0] a, pa;
        for (int c = 0; c < NUM_CH; c++) pos[c] = 0;
        forever begin
            ch = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (model_rr + k) % NUM_CH;
                if (ch < 0 && pos[c] < src_addr[c].size()) ch = c;
            end
            if (ch < 0) break;
            n = 1;
            while (pos[ch] + n < src_addr[ch].size() && n < MB) begin
                a  = src_addr[ch][pos[ch] + n];
                pa = src_addr[ch][pos[ch] + n - 1];
                if (a != pa + 4 || a[11:0] == 12'h000) break;
                n++;
            end
            exp_addr.push_back(src_addr[ch][pos[ch]]);
            exp_len.push_back(8'(n - 1));
            for (int i = 0; i < n; i++) begin
                exp_data.push_back(src_data[ch][pos[ch] + i]);
                exp_last.push_back(i == n - 1);
            end
            pos[ch] += n;
            model_rr = (ch + 1) % NUM_CH;
        end
    endtask

    task automatic load();
        build_expected();
        drive_inputs();
    endtask

    function automatic bit all_consumed();
        for (int c = 0; c < NUM_CH; c++)
            if (drv_pos[c] < src_addr[c].size()) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_check(string name, int budget);
        int n = 0;
        while (!(all_consumed() && obs_data.size() >= exp_data.size() &&
                 obs_addr.size() >= exp_addr.size() && idle && !m_data_valid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout: got %0d beats after %0d cycles, want %0d beats",
                     name, obs_data.size(), n, exp_data.size());
        end
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL %s hdr_count got %0d want %0d", name, obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i]) begin
                failures++;
                $display("FAIL %s hdr%0d got addr=%h len=%0d want addr=%h len=%0d", name, i,
                         obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
            end
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL %s beat_count got %0d want %0d", name, obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL %s beat%0d got data=%h last=%b want data=%h last=%b", name, i,
                         obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (proto_err != 0) begin
            failures++;
            $display("FAIL %s handshake_stability got %0d violations want 0", name, proto_err);
        end
    endtask

    task automatic do_reset();
        clear_all();
        drive_inputs();
        rstn = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_rr = 0;
        clear_prev();
    endtask

    task automatic wait_accepts(string name, int n);
        int k = 0;
        while (acc_total < n && k < 200) begin
            step();
            k++;
        end
        checks++;
        if (acc_total < n) begin
            failures++;
            $display("FAIL %s accept_wait got %0d accepts want %0d", name, acc_total, n);
        end
    endtask

    task automatic test_reset();
        s_valid = '0; s_addr = '0; s_data = '0; flush = 1'b0;
        m_burst_ready = 1'b1; m_data_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) drv_pos[c] = 0;
        clear_prev();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_ready !== '0) begin failures++;
            $display("FAIL reset s_ready got %b want 0", s_ready); end
        checks++; if (m_burst_valid !== 1'b0 || m_data_valid !== 1'b0 || m_data_last !== 1'b0) begin
            failures++; $display("FAIL reset valids got bv=%b dv=%b dl=%b want 0", m_burst_valid,
                                 m_data_valid, m_data_last); end
        checks++; if (m_burst_addr !== '0 || m_burst_len !== '0 || m_data !== '0) begin
            failures++; $display("FAIL reset payload got addr=%h len=%h data=%h want 0",
                                 m_burst_addr, m_burst_len, m_data); end
        checks++; if (idle !== 1'b1) begin failures++;
            $display("FAIL reset idle got %b want 1", idle); end
        rstn = 1'b1;
    endtask

    task automatic test_single_16();
        bp = 1'b0;
        clear_all();
        push_run(0, 32'h1000, 16, 32'd0);
        load();
        run_check("single16", 400);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000 || obs_len[0] !== 8'd15) begin
            failures++;
            $display("FAIL single16 header got n=%0d want one header addr=1000 len=15",
                     obs_addr.size());
        end
    endtask

    task automatic test_split_20();
        bp = 1'b0;
        clear_all();
        push_run(0, 32'h2000, 20, 32'h100);
        load();
        run_check("split20", 400);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[1] !== 32'h2040 || obs_len[1] !== 8'd3) begin
            failures++;
            $display("FAIL split20 second_header got n=%0d want addr=2040 len=3", obs_addr.size());
        end
    endtask

    task automatic test_4k_cross();
        bp = 1'b1;
        clear_all();
        push_run(0, 32'h0FF0, 8, 32'hA0);
        load();
        run_check("cross4k", 400);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 32'h0FF0 || obs_addr[1] !== 32'h1000) begin
            failures++;
            $display("FAIL cross4k headers got n=%0d want 0ff0 then 1000", obs_addr.size());
        end
    endtask

    task automatic test_two_src();
        bp = 1'b0;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            clear_all();
            push_run(0, 32'h0000, 4, 32'h10);
            push_run(1, 32'h0100, 4, 32'h20);
            load();
            run_check("two_src", 400);
            checks++;
            if (obs_addr.size() != 2 || obs_addr[0] !== 32'h0 || obs_addr[1] !== 32'h100) begin
                failures++;
                $display("FAIL two_src order rep%0d got n=%0d want ch0 (0) then ch1 (100)",
                         rep, obs_addr.size());
            end
        end
    endtask

    task automatic test_timeout();
        bp = 1'b0;
        clear_all();
        push_run(0, 32'h3000, 3, 32'h55);
        load();
        wait_accepts("timeout", 3);
        run_check("timeout", 400);
        checks++;
        if (hdr_rise_cyc - last_acc_cyc != TO + 2) begin
            failures++;
            $display("FAIL timeout latency got %0d want %0d", hdr_rise_cyc - last_acc_cyc, TO + 2);
        end
    endtask

    task automatic test_flush();
        bp = 1'b0;
        clear_all();
        push_run(0, 32'h3000, 3, 32'h77);
        load();
        wait_accepts("flush", 3);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_check("flush", 400);
        checks++;
        if (hdr_rise_cyc - last_acc_cyc != 3) begin
            failures++;
            $display("FAIL flush latency got %0d want 3", hdr_rise_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_reset_drain();
        int k = 0;
        bp = 1'b0;
        hold_data = 1'b1;
        clear_all();
        push_run(0, 32'h5000, 4, 32'hC0);
        load();
        while (!m_data_valid && k < 200) begin
            step();
            k++;
        end
        checks++;
        if (!m_data_valid) begin
            failures++;
            $display("FAIL rst_drain reach_drain got dv=0 want 1");
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (m_burst_valid !== 1'b0 || m_data_valid !== 1'b0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL rst_drain async got bv=%b dv=%b idle=%b want 0 0 1",
                     m_burst_valid, m_data_valid, idle);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_rr = 0;
        hold_data = 1'b0;
        clear_all();
        clear_prev();
        drive_inputs();
        repeat (30) step();
        checks++;
        if (obs_addr.size() != 0 || obs_data.size() != 0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL rst_drain stale got hdrs=%0d beats=%0d idle=%b want 0 0 1",
                     obs_addr.size(), obs_data.size(), idle);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int n;
        bp = 1'b1;
        for (int it = 0; it < 8; it++) begin
            clear_all();
            for (int c = 0; c < NUM_CH; c++) begin
                n = $urandom_range(0, 40);
                a = $urandom & 32'h000F_FFFC;
                for (int i = 0; i < n; i++) begin
                    src_addr[c].push_back(a);
                    src_data[c].push_back($urandom);
                    case ($urandom_range(0, 9))
                        0:       a = $urandom & 32'h000F_FFFC;
                        1:       a = ($urandom & 32'h000F_F000) - 32'(4 * $urandom_range(1, 6));
                        default: a = a + 32'd4;
                    endcase
                end
            end
            load();
            run_check("random", 4000);
        end
    endtask

    initial begin
        test_reset();
        test_single_16();
        test_split_20();
        test_4k_cross();
        test_two_src();
        test_timeout();
        test_flush();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
